// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle.
// Groups the ROM address/data pair, the redirect/halt controls from the back
// end and the valid/ready instruction handshake toward decode.
//   master : the fetch stage (drives rom_addr and the instr_* head outputs)
//   slave  : the surroundings (ROM, decoder, branch unit)
interface instr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    logic [ADDR_W-1:0]          rom_addr;
    logic [DATA_W-1:0]          rom_data;
    logic                       redirect_valid;
    logic [ADDR_W-1:0]          redirect_pc;
    logic                       halt;
    logic                       instr_valid;
    logic                       instr_ready;
    logic [DATA_W-1:0]          instr_data;
    logic [ADDR_W-1:0]          instr_pc;
    logic [$clog2(DEPTH):0]     fifo_count;

    modport master (
        output rom_addr,
        input  rom_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output fifo_count
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  fifo_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Owns the PC, drives the combinational program ROM address straight from the
// PC register and captures {pc, word} pairs into a DEPTH-entry FIFO that is
// presented to decode with a valid/ready handshake. Redirect flushes the FIFO
// and reloads the PC; halt stops new fetches while the FIFO keeps draining.
// Ports:
//   CLK, RST_N : rising-edge clock, asynchronous active-low reset
//   bus        : instr_fetch_if.master (ROM, redirect/halt, decode handshake)
module instr_fetch #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    instr_fetch_if.master      bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_W-1:0]             pc;
    logic [PW-1:0]                 rd_ptr, wr_ptr;
    logic [CW-1:0]                 count;
    logic [DEPTH-1:0][ADDR_W-1:0]  mem_pc;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_data;

    logic valid, pop, space, push;

    assign valid = (count != '0);
    assign pop   = valid & bus.instr_ready;
    // A full FIFO can still accept a word when the head leaves this cycle.
    assign space = (count < DEPTH_C) | pop;
    assign push  = space & ~bus.halt & ~bus.redirect_valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            mem_pc   <= '0;
            mem_data <= '0;
        end else if (bus.redirect_valid) begin
            // A same-cycle pop is a completed handshake; everything left is
            // stale and dropped by the pointer reset.
            pc     <= bus.redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]   <= pc;
                mem_data[wr_ptr] <= bus.rom_data;
                wr_ptr           <= wr_ptr + PW'(1);
                pc               <= pc + ADDR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    // Head comes straight out of storage, so decode sees registered values.
    assign bus.rom_addr    = pc;
    assign bus.instr_valid = valid;
    assign bus.instr_data  = mem_data[rd_ptr];
    assign bus.instr_pc    = mem_pc[rd_ptr];
    assign bus.fifo_count  = count;
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) bus();

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Program ROM: small image at 0x00..0x1F, zero elsewhere.
    logic [DW-1:0] rom_img [0:31];
    assign bus.rom_data = (bus.rom_addr < 16'd32) ? rom_img[bus.rom_addr[4:0]] : '0;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return (a < 16'd32) ? rom_img[a[4:0]] : '0;
    endfunction

    task automatic load_image();
        for (int i = 0; i < 32; i++) rom_img[i] = 32'h1000_0000 | i;
        rom_img[0]  = 32'h000A0006;
        rom_img[1]  = 32'h00032006;
        rom_img[2]  = 32'h00004006;
        rom_img[12] = 32'h00030008;
        rom_img[13] = 32'h00086042;
    endtask

    // Reference model: queue of {pc, data} pairs plus the fetch address.
    logic [AW+DW-1:0] mq[$];
    logic [AW-1:0]    m_pc;
    bit               m_fresh;   // no push since reset: head reads as zero
    bit               chk_on;
    int               n_chk, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 16'h0000;
        m_fresh = 1'b1;
    endtask

    task automatic model_edge();
        bit pop, push;
        pop = (mq.size() != 0) && bus.instr_ready;
        if (bus.redirect_valid) begin
            mq.delete();
            m_pc = bus.redirect_pc;
        end else begin
            push = ((mq.size() < DEPTH) || pop) && !bus.halt;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_pc, rom(m_pc)});
                m_pc    = m_pc + 16'd1;
                m_fresh = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST_N) model_edge();
        @(negedge CLK);
    endtask

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge CLK);
        if (RST_N && chk_on) begin
            check("valid", bus.instr_valid, (mq.size() != 0));
            check("count", bus.fifo_count, mq.size());
            check("rom_addr", bus.rom_addr, m_pc);
            if (mq.size() != 0)
                check("head", {bus.instr_pc, bus.instr_data}, mq[0]);
            else if (m_fresh)
                check("head_zero", {bus.instr_pc, bus.instr_data}, 0);
        end
    end

    task automatic expect_head(input string name, input logic [AW-1:0] pc, input logic [DW-1:0] d);
        check({name, "_valid"}, bus.instr_valid, 1);
        check({name, "_pair"}, {bus.instr_pc, bus.instr_data}, {pc, d});
    endtask

    // Asynchronous reset taken mid-cycle; outputs must clear without a clock.
    task automatic do_reset();
        #2 RST_N = 1'b0;
        #1;
        check("rst_valid", bus.instr_valid, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_rom_addr", bus.rom_addr, 16'h0000);
        check("rst_head", {bus.instr_pc, bus.instr_data}, 0);
        model_reset();
        @(negedge CLK);
        bus.redirect_valid = 1'b0;
        bus.halt = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic scen1();
        bus.instr_ready = 1'b1;
        check("s1_idle_valid", bus.instr_valid, 0);
        tick(); expect_head("s1_0", 16'h0000, 32'h000A0006);
        check("s1_count", bus.fifo_count, 1);
        tick(); expect_head("s1_1", 16'h0001, 32'h00032006);
        tick(); expect_head("s1_2", 16'h0002, 32'h00004006);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; chk_on = 1'b1;
        load_image();
        model_reset();
        bus.instr_ready = 1'b0;
        bus.halt = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;

        // 1: basic stream after reset
        @(negedge CLK);
        do_reset();
        scen1();

        // 2: backpressure from reset
        do_reset();
        bus.instr_ready = 1'b0;
        repeat (6) tick();
        check("s2_count_full", bus.fifo_count, 2);
        check("s2_rom_addr", bus.rom_addr, 16'h0002);
        bus.instr_ready = 1'b1;
        expect_head("s2_0", 16'h0000, 32'h000A0006);
        tick(); expect_head("s2_1", 16'h0001, 32'h00032006);
        tick(); expect_head("s2_2", 16'h0002, 32'h00004006);
        tick(); expect_head("s2_3", 16'h0003, 32'h10000003);

        // 3: redirect while streaming, one bubble
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h000C;
        tick();
        bus.redirect_valid = 1'b0;
        check("s3_bubble", bus.instr_valid, 0);
        tick(); expect_head("s3_c", 16'h000C, 32'h00030008);
        tick(); expect_head("s3_d", 16'h000D, 32'h00086042);

        // 4: halt drains the FIFO, PC holds, resume without skipping
        bus.halt = 1'b1;
        repeat (4) tick();
        check("s4_drained", bus.instr_valid, 0);
        check("s4_pc_held", bus.rom_addr, 16'h000E);
        bus.halt = 1'b0;
        tick(); expect_head("s4_resume", 16'h000E, 32'h1000000E);

        // 5: PC wrap, with an empty image so both sides read zero
        for (int i = 0; i < 32; i++) rom_img[i] = '0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hFFFF;
        tick();
        bus.redirect_valid = 1'b0;
        tick(); expect_head("s5_ffff", 16'hFFFF, 32'h0);
        tick(); expect_head("s5_wrap", 16'h0000, 32'h0);
        load_image();

        // 6: reset while full with a redirect pending, then restart
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0004;
        tick();
        bus.redirect_valid = 1'b0; bus.instr_ready = 1'b0;
        tick(); tick();
        check("s6_full", bus.fifo_count, 2);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0020;
        do_reset();
        scen1();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            bus.instr_ready    = ($urandom_range(0, 3) != 0);
            bus.halt           = ($urandom_range(0, 7) == 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = ($urandom_range(0, 3) == 0) ?
                                 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom_range(0, 40));
            if (c == 300) do_reset();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
